// File: rtl/prog_loader_if.sv
// Byte-stream and program-write bus between the UART source, the loader and instruction memory.
// The slave modport is the loader's view; master is the environment driving bytes and observing writes.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, prog_en, prog_addr, prog_data
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, prog_en, prog_addr, prog_data
    );
endinterface

// File: rtl/prog_loader.sv
// Framed UART program loader: MAGIC, 16-bit word count, LE payload, XOR checksum.
// Writes words into instruction memory and releases the core once the checksum matches.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic         clk,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         core_start,
    output logic         load_done,
    output logic         load_err,
    output logic [1:0]   err_code
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_lane;
    logic [23:0] r_word;
    logic [7:0]  r_chk;
    logic        r_rx_ready;
    logic        r_prog_en;
    logic [31:0] r_prog_addr;
    logic [31:0] r_prog_data;
    logic        r_core_start;
    logic        r_load_done;
    logic        r_load_err;
    logic [1:0]  r_err_code;

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_bad_len;
    logic        w_last_word;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_len       = {bus.rx_data, r_len[7:0]};
    assign w_bad_len   = (w_len == 16'd0) || ({1'b0, w_len} > MAX_W);
    assign w_last_word = (r_idx == (r_len - 16'd1));

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_lane       <= '0;
            r_word       <= '0;
            r_chk        <= '0;
            r_rx_ready   <= 1'b0;
            r_prog_en    <= 1'b0;
            r_prog_addr  <= '0;
            r_prog_data  <= '0;
            r_core_start <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            r_rx_ready <= 1'b1;
            r_prog_en  <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.rx_data == MAGIC) r_state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        r_len[7:0] <= bus.rx_data;
                        r_state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len[15:8] <= bus.rx_data;
                        if (w_bad_len) begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                            r_err_code <= 2'b01;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                            r_lane  <= '0;
                            r_chk   <= '0;
                        end
                    end
                    S_DATA: begin
                        r_chk  <= r_chk ^ bus.rx_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            2'd3: begin
                                // Word completes on lane 3; the write strobe lands the following cycle.
                                r_prog_en   <= 1'b1;
                                r_prog_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                                r_prog_data <= {bus.rx_data, r_word};
                                r_idx       <= r_idx + 16'd1;
                                if (w_last_word) r_state <= S_CHK;
                            end
                        endcase
                    end
                    S_CHK: begin
                        if (bus.rx_data == r_chk) begin
                            r_state      <= S_DONE;
                            r_load_done  <= 1'b1;
                            r_core_start <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                            r_err_code <= 2'b10;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    S_ERR: begin
                        if (bus.rx_data == MAGIC) begin
                            r_state    <= S_LEN_LO;
                            r_load_err <= 1'b0;
                            r_err_code <= 2'b00;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.prog_en   = r_prog_en;
    assign bus.prog_addr = r_prog_addr;
    assign bus.prog_data = r_prog_data;
    assign core_start    = r_core_start;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;
    assign err_code      = r_err_code;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model predicts writes and status,
// a monitor pops expected writes whenever prog_en is seen.
module tb_prog_loader;
    localparam logic [7:0]  MAGIC     = 8'hA5;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS = 4096;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk;
    logic start;
    logic core_start;
    logic load_done;
    logic load_err;
    logic [1:0] err_code;

    prog_loader_if bus();

    prog_loader #(
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS),
        .MAGIC     (MAGIC)
    ) dut (
        .clk        (clk),
        .start      (start),
        .bus        (bus),
        .core_start (core_start),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    wr_t sb[$];

    logic        m_done;
    logic        m_err;
    logic [1:0]  m_code;
    logic        ew_flag[$];
    logic [31:0] ew_addr[$];
    logic [31:0] ew_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the oldest predicted one, on the predicted cycle.
    always @(negedge clk) begin
        if (start === 1'b1 && bus.prog_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_prog_en", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("prog_addr", bus.prog_addr, e.addr);
                check("prog_data", bus.prog_data, e.data);
                check("prog_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Frame-level reference: hunt for MAGIC, read N, take 4N payload bytes, compare XOR.
    task automatic run_model(input logic [7:0] b[$]);
        int i;
        int n;
        int nw;
        logic [7:0] c;
        n = b.size();
        ew_flag.delete();
        ew_addr.delete();
        ew_data.delete();
        for (int k = 0; k < n; k++) begin
            ew_flag.push_back(1'b0);
            ew_addr.push_back(32'd0);
            ew_data.push_back(32'd0);
        end
        i = 0;
        while (i < n && !m_done) begin
            if (b[i] != MAGIC) begin
                i++;
                continue;
            end
            m_err  = 1'b0;
            m_code = 2'b00;
            if (i + 2 >= n) break;
            nw = int'(b[i+1]) + 256 * int'(b[i+2]);
            i += 3;
            if (nw == 0 || nw > MAX_WORDS) begin
                m_err  = 1'b1;
                m_code = 2'b01;
                continue;
            end
            c = 8'h00;
            for (int w = 0; w < nw; w++) begin
                int p;
                p = i + 4 * w;
                if (p + 3 >= n) break;
                ew_flag[p+3] = 1'b1;
                ew_addr[p+3] = BASE_ADDR + 32'(4 * w);
                ew_data[p+3] = {b[p+3], b[p+2], b[p+1], b[p]};
                c = c ^ b[p] ^ b[p+1] ^ b[p+2] ^ b[p+3];
            end
            i += 4 * nw;
            if (i >= n) break;
            if (b[i] == c) begin
                m_done = 1'b1;
            end else begin
                m_err  = 1'b1;
                m_code = 2'b10;
            end
            i++;
        end
    endtask

    // Called at a negedge; returns at the negedge just after the last byte is accepted.
    task automatic send(input logic [7:0] b[$], input int gapmax);
        run_model(b);
        for (int k = 0; k < b.size(); k++) begin
            int g;
            int waited;
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            bus.rx_valid = 1'b0;
            repeat (g) @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = b[k];
            waited = 0;
            while (bus.rx_ready !== 1'b1) begin
                @(negedge clk);
                waited++;
                if (waited > 20) begin
                    n_fail++;
                    $display("FAIL rx_ready_timeout: got 0, expected 1 within 20 cycles");
                    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
                    $fatal(1, "rx_ready never asserted");
                end
            end
            if (ew_flag[k]) sb.push_back('{addr: ew_addr[k], data: ew_data[k], cyc: cyc + 1});
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_core_start"}, 32'(core_start), 32'(m_done));
        check({tag, "_load_done"},  32'(load_done),  32'(m_done));
        check({tag, "_load_err"},   32'(load_err),   32'(m_err));
        check({tag, "_err_code"},   32'(err_code),   32'(m_code));
        repeat (2) @(negedge clk);
        check({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},   32'(bus.rx_ready), 32'd0);
        check({tag, "_prog_en"},    32'(bus.prog_en),  32'd0);
        check({tag, "_prog_addr"},  bus.prog_addr,     32'd0);
        check({tag, "_prog_data"},  bus.prog_data,     32'd0);
        check({tag, "_core_start"}, 32'(core_start),   32'd0);
        check({tag, "_load_done"},  32'(load_done),    32'd0);
        check({tag, "_load_err"},   32'(load_err),     32'd0);
        check({tag, "_err_code"},   32'(err_code),     32'd0);
    endtask

    // Reset is asserted between edges to exercise its asynchronous path.
    task automatic do_reset(input string tag);
        #2;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        sb.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        start  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] big[$];
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        start = 1'b1;
        @(negedge clk);

        fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send(fr, 0);
        check_status("t1_single_word");

        do_reset("rst_t2");
        fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send(fr, 0);
        check_status("t2_back_to_back");

        do_reset("rst_t3");
        fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        send(fr, 1);
        check_status("t3_bad_chk");

        fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send(fr, 1);
        check_status("t4_retry");

        do_reset("rst_t5");
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        send(fr, 0);
        check_status("t5_len_zero");

        fr = '{8'hA5, 8'h01, 8'h10};
        send(fr, 0);
        check_status("t6_len_too_big");

        do_reset("rst_t7");
        fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send(fr, 0);
        do_reset("t7_mid_frame");
        fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send(fr, 0);
        check_status("t7_reload");

        for (int it = 0; it < 10; it++) begin
            int nw;
            logic [7:0] c;
            logic [7:0] v;
            do_reset("rst_rand");
            fr.delete();
            repeat ($urandom_range(3, 0)) begin
                v = 8'($urandom_range(255, 0));
                if (v == MAGIC) v = 8'h5A;
                fr.push_back(v);
            end
            nw = int'($urandom_range(5, 1));
            fr.push_back(MAGIC);
            fr.push_back(8'(nw));
            fr.push_back(8'h00);
            c = 8'h00;
            for (int k = 0; k < 4 * nw; k++) begin
                v = 8'($urandom_range(255, 0));
                fr.push_back(v);
                c = c ^ v;
            end
            if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
            fr.push_back(c);
            fr.push_back(($urandom_range(1, 0) == 1) ? MAGIC : 8'($urandom_range(255, 0)));
            fr.push_back(8'($urandom_range(255, 0)));
            send(fr, int'($urandom_range(2, 0)));
            check_status("rand");
        end

        do_reset("rst_max");
        big.delete();
        big.push_back(MAGIC);
        big.push_back(8'(MAX_WORDS & 255));
        big.push_back(8'(MAX_WORDS >> 8));
        begin
            logic [7:0] c;
            logic [7:0] v;
            c = 8'h00;
            for (int k = 0; k < 4 * MAX_WORDS; k++) begin
                v = 8'($urandom_range(255, 0));
                big.push_back(v);
                c = c ^ v;
            end
            big.push_back(c);
        end
        send(big, 0);
        check_status("max_words");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
